// File: rtl/control_word_sequencer.sv
// control_word_sequencer: plays a loadable table of {control word, constant, hold} entries
// into the LEGv8 datapath, with free-run, single-step, loop and abort.
module control_word_sequencer #(
    parameter int CW_WIDTH   = 25,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16,
    parameter int HOLD_WIDTH = 8,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  prog_we,
    input  logic [AW-1:0]         prog_addr,
    input  logic [CW_WIDTH-1:0]   prog_cw,
    input  logic [DATA_WIDTH-1:0] prog_const,
    input  logic [HOLD_WIDTH-1:0] prog_hold,
    input  logic [AW-1:0]         last_addr,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  step_mode,
    input  logic                  step,
    input  logic                  loop_en,
    output logic [CW_WIDTH-1:0]   ControlWord,
    output logic [DATA_WIDTH-1:0] constant,
    output logic [AW-1:0]         pc,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [1:0] {IDLE, RUN, WAIT_STEP, DONE} state_t;

    state_t                state, state_n;
    logic [CW_WIDTH-1:0]   mem_cw    [DEPTH];
    logic [DATA_WIDTH-1:0] mem_const [DEPTH];
    logic [HOLD_WIDTH-1:0] mem_hold  [DEPTH];
    logic [CW_WIDTH-1:0]   cw_n;
    logic [DATA_WIDTH-1:0] const_n;
    logic [AW-1:0]         pc_n, load_addr;
    logic [HOLD_WIDTH-1:0] cnt, cnt_n;
    logic                  idle, load, adv, is_last;

    assign idle    = state == IDLE || state == DONE;
    assign busy    = state == RUN || state == WAIT_STEP;
    assign done    = state == DONE;
    // A last_addr behind pc lets the sequence run on and stop at the top entry.
    assign is_last = pc == last_addr || pc == AW'(DEPTH - 1);

    always_ff @(posedge clock) begin
        if (prog_we && idle) begin
            mem_cw[prog_addr]    <= prog_cw;
            mem_const[prog_addr] <= prog_const;
            mem_hold[prog_addr]  <= prog_hold;
        end
    end

    always_comb begin
        state_n   = state;
        cw_n      = ControlWord;
        const_n   = constant;
        pc_n      = pc;
        cnt_n     = cnt;
        load      = 1'b0;
        load_addr = '0;
        adv       = 1'b0;
        if (abort) begin
            state_n = IDLE;
            cw_n    = '0;
            const_n = '0;
            pc_n    = '0;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE, DONE: load = start;
                RUN: begin
                    if (cnt != '0) cnt_n = cnt - 1'b1;
                    else if (step_mode) state_n = WAIT_STEP;
                    else adv = 1'b1;
                end
                WAIT_STEP: adv = step;
                default: ;
            endcase
            if (adv) begin
                if (!is_last) begin
                    load      = 1'b1;
                    load_addr = pc + 1'b1;
                end else if (loop_en) begin
                    load = 1'b1;
                end else begin
                    state_n = DONE;
                    cw_n    = '0;
                    const_n = '0;
                    cnt_n   = '0;
                end
            end
            // Counter holds the remaining extra cycles; a hold of 0 behaves as 1.
            if (load) begin
                state_n = RUN;
                pc_n    = load_addr;
                cw_n    = mem_cw[load_addr];
                const_n = mem_const[load_addr];
                cnt_n   = (mem_hold[load_addr] == '0) ? '0 : mem_hold[load_addr] - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ControlWord <= '0;
            constant    <= '0;
            pc          <= '0;
            cnt         <= '0;
        end else begin
            state       <= state_n;
            ControlWord <= cw_n;
            constant    <= const_n;
            pc          <= pc_n;
            cnt         <= cnt_n;
        end
    end
endmodule

// File: doc/control_word_sequencer.md
Name: control_word_sequencer

Overview:
- Programmable player of {control word, constant, hold count} entries that drives the LEGv8 datapath's ControlWord and constant inputs.
- Replaces hand-timed control-word stimulus with a loadable, parametrised sequence memory.
- Supports free-run, single-step and loop modes plus abort.
- Sits directly in front of DatapathLEGv8; both share one clock.

Parameters:
- CW_WIDTH, 25, control word width ({SA,SB,DA,RegWrite,MemWrite,FS,Bsel,EN_Mem,EN_ALU}).
- DATA_WIDTH, 64, constant width.
- DEPTH, 16, number of sequence entries (power of two, >=2).
- HOLD_WIDTH, 8, width of per-entry hold count.
- AW, $clog2(DEPTH), address width (derived; not overridden).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- prog_we  in  1  write entry at prog_addr.
- prog_addr  in  AW  entry address.
- prog_cw  in  CW_WIDTH  control word to store.
- prog_const  in  DATA_WIDTH  constant to store.
- prog_hold  in  HOLD_WIDTH  cycles to present entry (0 treated as 1).
- last_addr  in  AW  index of final entry in sequence.
- start  in  1  begin sequence (IDLE/DONE only).
- abort  in  1  terminate sequence.
- step_mode  in  1  pause after every entry.
- step  in  1  advance while paused.
- loop_en  in  1  wrap to entry 0 after last_addr.
- ControlWord  out  CW_WIDTH  registered control word to datapath.
- constant  out  DATA_WIDTH  registered constant to datapath.
- pc  out  AW  index of entry currently presented.
- busy  out  1  high in RUN or WAIT_STEP.
- done  out  1  high in DONE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; ControlWord=0, constant=0, pc=0, busy=0, done=0, hold counter=0. Sequence memory is not cleared.
- States:
  - IDLE: outputs zero.
  - RUN: entry presented, counter running.
  - WAIT_STEP: entry held, waiting for step.
  - DONE: outputs zero, done=1.
- Programming: prog_we writes the memory on the rising edge, but only in IDLE or DONE. Writes while busy are ignored (no corruption).
- Start: start=1 at an edge in IDLE/DONE moves to RUN and sets pc=0. ControlWord/constant take mem[0] at that edge (1-cycle latency from sampled start). The counter loads max(hold,1)-1 and done clears. Start in RUN/WAIT_STEP is ignored.
- RUN, counter!=0: decrement; outputs stable.
- RUN, counter==0:
  - step_mode=1: go to WAIT_STEP and hold outputs.
  - else: advance.
- WAIT_STEP: outputs held indefinitely; step=1 at an edge performs advance. step in other states is ignored. step_mode sampled continuously; clearing it while in WAIT_STEP does not self-advance (step still required).
- Advance:
  - pc!=last_addr: pc+1, load that entry and its counter.
  - pc==last_addr with loop_en=1: pc=0, load entry 0.
  - pc==last_addr with loop_en=0: DONE, outputs zero, pc holds last_addr.
- Entry n is therefore presented for exactly max(hold_n,1) cycles in free-run.
- last_addr is sampled at each advance. If last_addr < pc, the sequence runs to DEPTH-1 and then treats DEPTH-1 as last.
- Abort: abort=1 at an edge in any state goes to IDLE with outputs zero and pc=0. abort has priority over start, step and advance in the same cycle.
- start and abort together in IDLE: remain IDLE.
- No combinational path from any input to ControlWord/constant.

Test Plan:
- Reset mid-run: program 3 entries, start, assert reset low during entry 1 -> ControlWord=0, constant=0, busy=0 immediately (asynchronous); memory still plays correctly on the next start.
- Free-run: entries {cw=25'h1F01645,const=4,hold=0},{cw=25'h1F00A45,const=6,hold=2},{cw=25'h1F00245,const=35,hold=1}, last_addr=2. Pulse start -> const 4 for 1 cycle, 6 for 2 cycles, 35 for 1 cycle, then done=1, outputs 0, pc=2.
- Loop: same program, loop_en=1 -> const pattern 4,6,6,35,4,6,6,35… with busy held 1; abort -> IDLE next edge, outputs 0.
- Step mode: step_mode=1 -> after entry 0's cycle, pc=0 held for 10 cycles with const=4. A step pulse moves to const=6 for 2 cycles, then holds waiting again.
- Protection: prog_we to addr 1 with const=200 while busy -> entry 1 still outputs 6. Start while busy is ignored. Start+abort together in IDLE leaves IDLE.
- Parametrisation: DEPTH=4, DATA_WIDTH=32, last_addr=3, all holds=255 -> each entry presented exactly 255 cycles; done after 1020 cycles.
